// File: rtl/branch_predictor_table_if.sv
// Lookup/update/flush bundle for branch_predictor_table; the ghr/upd_hist
// signals exist only when BPT_GSHARE_EN is defined.
interface branch_predictor_table_if #(
  parameter int INDEX_BITS = 5
);
  logic                  rd_en;
  logic [INDEX_BITS-1:0] rd_addr;
  logic                  prediction;
  logic                  pred_valid;
  logic                  upd_en;
  logic [INDEX_BITS-1:0] upd_addr;
  logic                  upd_taken;
  logic                  flush;
  logic                  busy;
`ifdef BPT_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;
  logic [INDEX_BITS-1:0] upd_hist;

  modport master (
    output rd_en, rd_addr, upd_en, upd_addr, upd_taken, flush, upd_hist,
    input  prediction, pred_valid, busy, ghr
  );
  modport slave (
    input  rd_en, rd_addr, upd_en, upd_addr, upd_taken, flush, upd_hist,
    output prediction, pred_valid, busy, ghr
  );
`else
  modport master (
    output rd_en, rd_addr, upd_en, upd_addr, upd_taken, flush,
    input  prediction, pred_valid, busy
  );
  modport slave (
    input  rd_en, rd_addr, upd_en, upd_addr, upd_taken, flush,
    output prediction, pred_valid, busy
  );
`endif
endinterface

// File: rtl/branch_predictor_table.sv
// Saturating-counter branch history table with read-after-write bypass and a
// sequenced flush; define BPT_GSHARE_EN for gshare (PC ^ global history) indexing.
module branch_predictor_table #(
  parameter int INDEX_BITS = 5,
  parameter int CNT_BITS   = 2
) (
  input  logic                    clk,
  input  logic                    arst_n,
  branch_predictor_table_if.slave bus
);
  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CNT_BITS-1:0]   INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0]   MAX  = {CNT_BITS{1'b1}};
  localparam logic [INDEX_BITS-1:0] LAST = {INDEX_BITS{1'b1}};

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                state_reg, state_next;
  logic [INDEX_BITS-1:0] ptr_reg, ptr_next;
  logic [CNT_BITS-1:0]   cnt_reg  [DEPTH];
  logic [CNT_BITS-1:0]   cnt_next [DEPTH];
  logic                  prediction_reg, prediction_next;
  logic                  pred_valid_reg, pred_valid_next;

  logic                  idle;
  logic                  upd_accept;
  logic                  flush_start;
  logic [INDEX_BITS-1:0] rd_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [CNT_BITS-1:0]   upd_cur;
  logic [CNT_BITS-1:0]   upd_val;
  logic [CNT_BITS-1:0]   rd_val;

  assign idle        = (state_reg == IDLE);
  // An update arriving with the flush pulse is dropped, never applied.
  assign upd_accept  = idle && bus.upd_en && !bus.flush;
  assign flush_start = idle && bus.flush;

`ifdef BPT_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr_reg, ghr_next;

  assign rd_idx  = bus.rd_addr ^ ghr_reg;
  assign upd_idx = bus.upd_addr ^ bus.upd_hist;
  assign bus.ghr = ghr_reg;

  always_comb begin
    ghr_next = ghr_reg;
    if (flush_start) begin
      ghr_next = '0;
    end else if (upd_accept) begin
      ghr_next = INDEX_BITS'({ghr_reg, bus.upd_taken});
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ghr_reg <= '0;
    end else begin
      ghr_reg <= ghr_next;
    end
  end
`else
  assign rd_idx  = bus.rd_addr;
  assign upd_idx = bus.upd_addr;
`endif

  always_comb begin
    upd_cur = cnt_reg[upd_idx];
    upd_val = upd_cur;
    if (bus.upd_taken) begin
      if (upd_cur != MAX) begin
        upd_val = upd_cur + CNT_BITS'(1);
      end
    end else if (upd_cur != '0) begin
      upd_val = upd_cur - CNT_BITS'(1);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign cnt_next[gi] =
        (!idle && ptr_reg == INDEX_BITS'(gi))      ? INIT    :
        (upd_accept && upd_idx == INDEX_BITS'(gi)) ? upd_val :
                                                     cnt_reg[gi];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_reg[i] <= INIT;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        cnt_reg[i] <= cnt_next[i];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (bus.flush) begin
          state_next = FLUSH;
          ptr_next   = '0;
        end
      end
      FLUSH: begin
        ptr_next = ptr_reg + INDEX_BITS'(1);
        if (ptr_reg == LAST) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // Same-index read and update in one cycle sees the post-update counter.
  always_comb begin
    rd_val          = (upd_accept && upd_idx == rd_idx) ? upd_val : cnt_reg[rd_idx];
    prediction_next = prediction_reg;
    pred_valid_next = 1'b0;
    if (bus.rd_en) begin
      if (idle) begin
        prediction_next = rd_val[CNT_BITS-1];
        pred_valid_next = 1'b1;
      end else begin
        prediction_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      prediction_reg <= 1'b0;
      pred_valid_reg <= 1'b0;
    end else begin
      prediction_reg <= prediction_next;
      pred_valid_reg <= pred_valid_next;
    end
  end

  assign bus.prediction = prediction_reg;
  assign bus.pred_valid = pred_valid_reg;
  assign bus.busy       = !idle;

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed and random checks of branch_predictor_table against an array-based
// reference model; gshare checks are compiled when BPT_GSHARE_EN is defined.
module tb_branch_predictor_table;
  localparam int IB    = 5;
  localparam int CB    = 2;
  localparam int DEPTH = 1 << IB;
  localparam int INIT  = (1 << (CB - 1)) - 1;
  localparam int MAX   = (1 << CB) - 1;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_table_if #(.INDEX_BITS(IB)) bus ();

  branch_predictor_table #(.INDEX_BITS(IB), .CNT_BITS(CB)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer counters plus a remaining-flush-cycles count.
  int model [DEPTH];
  int m_pred, m_valid, m_busy_left, m_ghr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = INIT;
    m_pred = 0;
    m_valid = 0;
    m_busy_left = 0;
    m_ghr = 0;
  endtask

  // One clock: drive inputs, advance the model, then compare on the falling edge.
  task automatic cycle(input bit rd, input int ra, input bit up, input int ua,
                       input bit tk, input bit fl, input int uh);
    int ridx, uidx;
    bus.rd_en     = rd;
    bus.rd_addr   = IB'(ra);
    bus.upd_en    = up;
    bus.upd_addr  = IB'(ua);
    bus.upd_taken = tk;
    bus.flush     = fl;
`ifdef BPT_GSHARE_EN
    bus.upd_hist  = IB'(uh);
    ridx = (ra ^ m_ghr) % DEPTH;
    uidx = (ua ^ uh) % DEPTH;
`else
    ridx = ra % DEPTH;
    uidx = ua % DEPTH + 0 * uh;
`endif
    if (m_busy_left > 0) begin
      m_busy_left--;
      if (rd) m_pred = 0;
      m_valid = 0;
    end else begin
      if (up && !fl) begin
        if (tk) model[uidx] = (model[uidx] + 1 > MAX) ? MAX : model[uidx] + 1;
        else    model[uidx] = (model[uidx] - 1 < 0) ? 0 : model[uidx] - 1;
`ifdef BPT_GSHARE_EN
        m_ghr = ((m_ghr << 1) | int'(tk)) % DEPTH;
`endif
      end
      if (rd) begin
        m_pred  = model[ridx] >> (CB - 1);
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      if (fl) begin
        m_busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) model[i] = INIT;
        m_ghr = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    $display("t=%0t rd=%0b ra=%0d up=%0b ua=%0d tk=%0b fl=%0b -> pred=%0b valid=%0b busy=%0b",
             $time, rd, ra, up, ua, tk, fl, bus.prediction, bus.pred_valid, bus.busy);
    check("pred_valid", 32'(bus.pred_valid), 32'(m_valid));
    check("prediction", 32'(bus.prediction), 32'(m_pred));
    check("busy", 32'(bus.busy), 32'(m_busy_left > 0));
`ifdef BPT_GSHARE_EN
    check("ghr", 32'(bus.ghr), 32'(m_ghr));
`endif
  endtask

  task automatic do_read(input int a);
    cycle(1'b1, a, 1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic do_upd(input int a, input bit tk);
    cycle(1'b0, 0, 1'b1, a, tk, 1'b0, 0);
  endtask

  int busy_cnt;
  int ra, ua;

  initial begin
    bus.rd_en = 1'b0;
    bus.rd_addr = '0;
    bus.upd_en = 1'b0;
    bus.upd_addr = '0;
    bus.upd_taken = 1'b0;
    bus.flush = 1'b0;
`ifdef BPT_GSHARE_EN
    bus.upd_hist = '0;
`endif
    model_reset();
    #12;
    check("reset_pred_valid", 32'(bus.pred_valid), 32'd0);
    check("reset_prediction", 32'(bus.prediction), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;

    // Basic lookup and single increment
    do_read(3);
    check("idx3_init_pred", 32'(bus.prediction), 32'd0);
    do_upd(3, 1'b1);
    do_read(3);
    check("idx3_after_taken", 32'(bus.prediction), 32'd1);

    // Saturation in both directions
    for (int i = 0; i < 5; i++) do_upd(7, 1'b1);
    do_upd(7, 1'b0);
    do_read(7);
    check("idx7_sat_then_dec", 32'(bus.prediction), 32'd1);
    for (int i = 0; i < 5; i++) do_upd(8, 1'b0);
    do_read(8);
    check("idx8_floor", 32'(bus.prediction), 32'd0);
    do_upd(8, 1'b1);
    do_read(8);
    check("idx8_no_wrap", 32'(bus.prediction), 32'd0);

    // Bypass and index independence
    cycle(1'b1, 4, 1'b1, 4, 1'b1, 1'b0, 0);
    check("bypass_same_idx", 32'(bus.prediction), 32'd1);
    cycle(1'b1, 5, 1'b1, 4, 1'b1, 1'b0, 0);
    check("bypass_diff_idx", 32'(bus.prediction), 32'd0);

    // Flush with updates and flush pulses in flight
    for (int e = 10; e < 14; e++) for (int k = 0; k < 3; k++) do_upd(e, 1'b1);
    busy_cnt = 0;
    cycle(1'b1, 10, 1'b1, 11, 1'b0, 1'b1, 0);
    busy_cnt += int'(bus.busy);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'($urandom_range(0, 1)), 10 + (i % 4), 1'b1, 10 + (i % 4), 1'b1,
            1'(i % 7 == 3), 0);
      busy_cnt += int'(bus.busy);
    end
    check("flush_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) do_read(i);

    // Asynchronous reset in the middle of a flush
    for (int e = 20; e < 23; e++) for (int k = 0; k < 2; k++) do_upd(e, 1'b1);
    cycle(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 10; i++) do_read(i);
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_pred_valid", 32'(bus.pred_valid), 32'd0);
    check("arst_prediction", 32'(bus.prediction), 32'd0);
    model_reset();
    @(negedge clk);
    arst_n = 1'b1;
    do_upd(20, 1'b1);
    do_read(20);
    check("post_arst_init", 32'(bus.prediction), 32'd1);
    busy_cnt = 0;
    cycle(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 0);
    busy_cnt += int'(bus.busy);
    for (int i = 0; i < DEPTH; i++) begin
      do_read(i);
      busy_cnt += int'(bus.busy);
    end
    check("reflush_busy_cycles", 32'(busy_cnt), 32'(DEPTH));

`ifdef BPT_GSHARE_EN
    // Global history shifting and hashed indexing
    cycle(1'b0, 0, 1'b1, 20, 1'b1, 1'b0, 0);
    cycle(1'b0, 0, 1'b1, 21, 1'b1, 1'b0, 0);
    cycle(1'b0, 0, 1'b1, 22, 1'b0, 1'b0, 0);
    check("ghr_00110", 32'(bus.ghr), 32'd6);
    cycle(1'b1, 1, 1'b0, 0, 1'b0, 1'b0, 0);
    check("gshare_idx7_init", 32'(bus.prediction), 32'd0);
    cycle(1'b0, 0, 1'b1, 1, 1'b1, 1'b0, 6);
    cycle(1'b1, 7 ^ m_ghr, 1'b0, 0, 1'b0, 1'b0, 0);
    check("gshare_idx7_inc", 32'(bus.prediction), 32'd1);
`endif

    // Random traffic, biased towards shared indices to exercise the bypass
    for (int i = 0; i < 300; i++) begin
      ra = $urandom_range(0, DEPTH - 1);
      ua = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, DEPTH - 1);
      cycle(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), ua,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0),
            $urandom_range(0, DEPTH - 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
- Parametrised successor to the 2-bit branch history table.
- Holds 2^INDEX_BITS saturating counters, each CNT_BITS wide, indexed by low PC bits.
- Read port: registered prediction, one-cycle latency. Write port: independent update port that resolves branches from EX.
- Adds read-after-write bypass, saturation for any counter width, a sequenced flush, and an optional gshare global-history mode.

Parameters:
- INDEX_BITS, 5, number of PC index bits; table depth = 2^INDEX_BITS.
- CNT_BITS, 2, saturating counter width; legal range 1..4.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- rd_en  in  1  lookup request.
- rd_addr  in  INDEX_BITS  lookup index (PC low bits).
- prediction  out  1  taken prediction for the previous cycle's lookup.
- pred_valid  out  1  prediction is meaningful.
- upd_en  in  1  resolved-branch update strobe.
- upd_addr  in  INDEX_BITS  index of the resolved branch.
- upd_taken  in  1  resolved outcome; a jump counts as taken.
- flush  in  1  one-cycle pulse that starts a table reinit.
- busy  out  1  flush in progress.

Behaviour:
- Constants: INIT = 2^(CNT_BITS-1)-1 (weakly not-taken); MAX = 2^CNT_BITS-1.
- Reset (arst_n=0, async):
  - every counter = INIT; prediction=0, pred_valid=0, busy=0; FSM=IDLE; flush pointer=0.
  - Reset mid-flush aborts the flush immediately.
- Counter update (registered on the clk edge when upd_en=1, FSM=IDLE):
  - taken: cnt = (cnt==MAX) ? MAX : cnt+1.
  - not taken: cnt = (cnt==0) ? 0 : cnt-1.
  - No wrap-around in either direction.
- Lookup:
  - On the clk edge with rd_en=1: prediction <= MSB of the entry; pred_valid <= 1.
  - rd_en=0: pred_valid <= 0; prediction holds its value.
  - Latency is exactly 1 cycle.
- Bypass: rd_en and upd_en in the same cycle on the same index returns the MSB of the post-update value.
- Different indices in the same cycle are fully independent.
- FSM IDLE -> FLUSH:
  - Triggered on flush=1. Pointer=0, busy=1 from the next cycle.
  - An update in the same cycle as flush is dropped.
- FSM FLUSH:
  - Each cycle, entry[pointer] = INIT and pointer increments.
  - After entry 2^INDEX_BITS-1 is written: FSM -> IDLE, busy=0. Flush takes exactly 2^INDEX_BITS cycles.
  - During FLUSH: upd_en is ignored; lookups return prediction=0 with pred_valid=0.
  - A flush pulse during FLUSH is ignored; the flush does not restart.
- CNT_BITS=1: counter = last outcome; INIT=0.

Optional Feature:
- Macro: BPT_GSHARE_EN.
- When defined:
  - Adds port ghr (out, INDEX_BITS): global history register, reset to 0.
  - Adds port upd_hist (in, INDEX_BITS): the ghr value sampled at lookup time, returned by the pipeline with the resolved branch.
  - Lookup index = rd_addr ^ ghr. Update index = upd_addr ^ upd_hist.
  - On each accepted update: ghr <= {ghr[INDEX_BITS-2:0], upd_taken}.
  - Flush clears ghr to 0 at FLUSH entry.
  - Bypass compares the hashed indices.
- When not defined: no extra ports; indices are used directly.

Test Plan:
- Reset, then read idx 3 -> next cycle prediction=0, pred_valid=1. Upd idx 3 taken once, then read -> prediction=1 (cnt 1->2).
- Saturation: 5 taken updates to idx 7, then 1 not-taken -> cnt=2, prediction=1. 5 not-taken to idx 8 then read -> cnt=0, prediction=0.
- Same-cycle read+update idx 4 taken from INIT -> prediction=1 in the following cycle (bypass). Read idx 5 with update idx 4 -> prediction=0.
- Flush after driving several entries to 3 -> busy=1 for exactly 32 cycles; updates and flush pulses during that time are ignored; afterwards all 32 reads give prediction=0.
- Assert arst_n low at flush cycle 10 -> busy=0 at once; all counters=INIT; next flush runs a full 32 cycles.
- BPT_GSHARE_EN: updates taken, taken, not-taken -> ghr=5'b00110. Read addr 1 -> index 7. Update addr 1 with upd_hist=6, taken -> entry 7 incremented.
